// File: rtl/snn_mem_load_ctrl_if.sv
// snn_mem_load_ctrl_if: command byte stream in, parameter-memory bus and status out.
//   master: byte source and memory side (drives frame_start, rx_*, mem_rdata)
//   slave : the load controller (drives mem_*, tx_data, busy, done, error)
interface snn_mem_load_ctrl_if #(
  parameter int N  = 8,
  parameter int AW = 9
);
  logic          frame_start;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic [N-1:0]  mem_rdata;
  logic [AW-1:0] mem_addr;
  logic [N-1:0]  mem_wdata;
  logic          mem_we;
  logic [N-1:0]  tx_data;
  logic          busy;
  logic          done;
  logic          error;
  modport master (
    output frame_start, rx_data, rx_valid, mem_rdata,
    input  mem_addr, mem_wdata, mem_we, tx_data, busy, done, error
  );
  modport slave (
    input  frame_start, rx_data, rx_valid, mem_rdata,
    output mem_addr, mem_wdata, mem_we, tx_data, busy, done, error
  );
endinterface

// File: rtl/snn_mem_load_ctrl.sv
// snn_mem_load_ctrl: decodes framed command bytes into parameter-memory writes, read-back and clear.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of snn_mem_load_ctrl_if (byte stream in, memory bus and status out)
module snn_mem_load_ctrl #(
  parameter int         M         = 320,
  parameter int         N         = 8,
  parameter int         AW        = 9,
  parameter logic [7:0] CMD_WRITE = 8'h01,
  parameter logic [7:0] CMD_READ  = 8'h02,
  parameter logic [7:0] CMD_CLEAR = 8'h03
) (
  input logic               clk,
  input logic               rst_n,
  snn_mem_load_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, CMD, ADDR_H, ADDR_L, WRITE, READ, CLEAR, IGNORE} state_t;
  localparam logic [AW-1:0] LAST = AW'(M - 1);
  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d, addr_inc;
  logic [7:0]    addr_h_q, addr_h_d;
  logic          wr_q, wr_d;
  logic [N-1:0]  wdata_q, wdata_d, tx_q, tx_d;
  logic          we_q, we_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic          acc;
  logic [15:0]   full;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      addr_h_q <= '0;
      wr_q     <= 1'b0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      tx_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      addr_h_q <= addr_h_d;
      wr_q     <= wr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    addr_h_d = addr_h_q;
    wr_d     = wr_q;
    wdata_d  = wdata_q;
    we_d     = 1'b0;
    tx_d     = tx_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = err_q;
    // frame_start steals the byte of the same cycle; busy blocks bytes during a sweep
    acc      = bus.rx_valid && !busy_q && !bus.frame_start;
    addr_inc = (addr_q == LAST) ? '0 : addr_q + 1'b1;
    full     = {addr_h_q, bus.rx_data};
    case (state_q)
      CMD: if (acc) begin
        if (bus.rx_data == CMD_WRITE || bus.rx_data == CMD_READ) begin
          state_d = ADDR_H;
          wr_d    = bus.rx_data == CMD_WRITE;
        end else if (bus.rx_data == CMD_CLEAR) begin
          state_d = CLEAR;
          busy_d  = 1'b1;
          addr_d  = '0;
          we_d    = 1'b1;
          wdata_d = '0;
        end else begin
          state_d = IGNORE;
          err_d   = 1'b1;
        end
      end
      ADDR_H: if (acc) begin
        addr_h_d = bus.rx_data;
        state_d  = ADDR_L;
      end
      ADDR_L: if (acc) begin
        if (full >= 16'(M)) begin
          err_d   = 1'b1;
          state_d = IGNORE;
        end else begin
          addr_d  = full[AW-1:0];
          state_d = wr_q ? WRITE : READ;
        end
      end
      // address advances the cycle after the write strobe so the write lands at the old address
      WRITE: begin
        if (we_q) addr_d = addr_inc;
        if (acc) begin
          we_d    = 1'b1;
          wdata_d = bus.rx_data;
        end
      end
      // tx_data follows the combinational read data one cycle behind the address
      READ: begin
        tx_d = bus.mem_rdata;
        if (acc) addr_d = addr_inc;
      end
      CLEAR: if (addr_q == LAST) begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        addr_d  = '0;
      end else begin
        addr_d = addr_inc;
        we_d   = 1'b1;
      end
      default: ;
    endcase
    if (bus.frame_start && state_q != CLEAR) begin
      state_d = CMD;
      err_d   = 1'b0;
    end
  end
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_we    = we_q;
  assign bus.tx_data   = tx_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.error     = err_q;
endmodule

// File: tb/tb_snn_mem_load_ctrl.sv
// tb_snn_mem_load_ctrl: directed frames against a transaction-level model of expected writes and status.
module tb_snn_mem_load_ctrl;
  localparam int M = 320, N = 8, AW = 9;
  localparam logic [7:0] CMD_WRITE = 8'h01, CMD_READ = 8'h02, CMD_CLEAR = 8'h03;
  typedef struct {int a; logic [7:0] d;} wr_t;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic clr_mem = 1'b1;
  always #5 clk = ~clk;
  snn_mem_load_ctrl_if #(.N(N), .AW(AW)) bus ();
  snn_mem_load_ctrl #(.M(M), .N(N), .AW(AW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  logic [7:0] mem [M];
  logic [7:0] gmem [M];
  wr_t wq[$];
  logic exp_err, exp_busy, exp_done;
  int passed = 0, total = 0;
  assign bus.mem_rdata = (int'(bus.mem_addr) < M) ? mem[bus.mem_addr] : 8'h00;
  always @(posedge clk)
    if (clr_mem) for (int i = 0; i < M; i++) mem[i] <= 8'h00;
    else if (bus.mem_we && int'(bus.mem_addr) < M) mem[bus.mem_addr] <= bus.mem_wdata;
  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endfunction
  always @(negedge clk) if (rst_n) begin
    chk("error", 32'(bus.error), 32'(exp_err));
    chk("busy", 32'(bus.busy), 32'(exp_busy));
    chk("done", 32'(bus.done), 32'(exp_done));
    chk("addr_range", 32'(int'(bus.mem_addr) < M), 32'd1);
    if (bus.mem_we) begin
      chk("we_expected", 32'(wq.size() > 0), 32'd1);
      if (wq.size() > 0) begin
        chk("we_addr", 32'(bus.mem_addr), 32'(wq[0].a));
        chk("we_data", 32'(bus.mem_wdata), 32'(wq[0].d));
        void'(wq.pop_front());
      end
    end
  end
  task automatic fs();
    @(posedge clk); #1 bus.frame_start = 1'b1;
    @(posedge clk); #1 bus.frame_start = 1'b0;
    exp_err = 1'b0;
  endtask
  task automatic put(input logic [7:0] b);
    repeat (2) @(posedge clk);
    #1 bus.rx_valid = 1'b1; bus.rx_data = b;
    @(posedge clk); #1 bus.rx_valid = 1'b0;
  endtask
  task automatic burst(input logic [15:0] a, input int n, input logic [7:0] d0, input logic [7:0] d1);
    int p;
    logic [7:0] d;
    put(CMD_WRITE); put(a[15:8]); put(a[7:0]);
    if (int'(a) >= M) exp_err = 1'b1;
    p = int'(a);
    for (int i = 0; i < n; i++) begin
      d = (i == 0) ? d0 : d1;
      put(d);
      if (int'(a) < M) begin
        wq.push_back('{a: p, d: d});
        gmem[p] = d;
        p = (p + 1) % M;
      end
    end
    @(posedge clk); #1;
    if (int'(a) < M) chk("end_addr", 32'(bus.mem_addr), 32'(p));
    chk("wq_drained", 32'(wq.size()), 32'd0);
  endtask
  initial begin
    int bad;
    exp_err = 1'b0; exp_busy = 1'b0; exp_done = 1'b0;
    bus.frame_start = 1'b0; bus.rx_valid = 1'b0; bus.rx_data = 8'h00;
    for (int i = 0; i < M; i++) gmem[i] = 8'h00;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_we", 32'(bus.mem_we), 32'd0);
    chk("rst_wdata", 32'(bus.mem_wdata), 32'd0);
    chk("rst_tx", 32'(bus.tx_data), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_err", 32'(bus.error), 32'd0);
    @(posedge clk); #1 clr_mem = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    put(CMD_WRITE);
    fs(); burst(16'h0005, 2, 8'hAA, 8'hBB);
    chk("wr_addr_lit", 32'(bus.mem_addr), 32'd7);
    chk("wr_mem5_lit", 32'(mem[5]), 32'hAA);
    chk("wr_mem6_lit", 32'(mem[6]), 32'hBB);
    fs(); burst(16'h013F, 2, 8'h11, 8'h22);
    chk("wrap_mem319_lit", 32'(mem[319]), 32'h11);
    chk("wrap_mem0_lit", 32'(mem[0]), 32'h22);
    chk("wrap_addr_lit", 32'(bus.mem_addr), 32'd1);
    fs(); put(CMD_READ); put(8'h00); put(8'h05);
    @(posedge clk); #1;
    chk("rd_tx0_lit", 32'(bus.tx_data), 32'hAA);
    chk("rd_tx0_model", 32'(bus.tx_data), 32'(gmem[5]));
    put(8'hFF);
    @(posedge clk); #1;
    chk("rd_tx1_lit", 32'(bus.tx_data), 32'hBB);
    chk("rd_tx1_model", 32'(bus.tx_data), 32'(gmem[6]));
    chk("rd_addr_lit", 32'(bus.mem_addr), 32'd6);
    fs(); burst(16'h0140, 2, 8'h33, 8'h44);
    chk("bad_addr_err_lit", 32'(bus.error), 32'd1);
    fs();
    chk("err_clear_lit", 32'(bus.error), 32'd0);
    put(8'h7F);
    exp_err = 1'b1;
    @(posedge clk); #1;
    chk("bad_op_err_lit", 32'(bus.error), 32'd1);
    fs();
    repeat (2) @(posedge clk);
    #1 bus.frame_start = 1'b1; bus.rx_valid = 1'b1; bus.rx_data = CMD_CLEAR;
    @(posedge clk); #1 bus.frame_start = 1'b0; bus.rx_valid = 1'b0;
    exp_err = 1'b0;
    burst(16'h000A, 1, 8'h5A, 8'h00);
    chk("tie_mem10_lit", 32'(mem[10]), 32'h5A);
    fs(); put(CMD_CLEAR);
    exp_busy = 1'b1;
    for (int a = 0; a < M; a++) begin
      wq.push_back('{a: a, d: 8'h00});
      gmem[a] = 8'h00;
    end
    for (int k = 1; k <= M; k++) begin
      @(posedge clk); #1;
      bus.frame_start = (k == 100);
      bus.rx_valid = (k == 200);
      bus.rx_data = CMD_WRITE;
    end
    exp_busy = 1'b0; exp_done = 1'b1;
    @(posedge clk); #1 exp_done = 1'b0;
    chk("clr_drained", 32'(wq.size()), 32'd0);
    chk("clr_addr_lit", 32'(bus.mem_addr), 32'd0);
    chk("clr_mem5_lit", 32'(mem[5]), 32'd0);
    chk("clr_mem319_lit", 32'(mem[319]), 32'd0);
    put(CMD_WRITE);
    fs(); put(CMD_WRITE); put(8'h00); put(8'h20); put(8'hAB);
    chk("mid_we_before", 32'(bus.mem_we), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_we", 32'(bus.mem_we), 32'd0);
    chk("mid_rst_addr", 32'(bus.mem_addr), 32'd0);
    chk("mid_rst_wdata", 32'(bus.mem_wdata), 32'd0);
    chk("mid_rst_tx", 32'(bus.tx_data), 32'd0);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    exp_err = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_rst_mem_lit", 32'(mem[32]), 32'd0);
    rst_n = 1'b1;
    fs(); burst(16'h0021, 1, 8'hCD, 8'h00);
    chk("post_rst_mem_lit", 32'(mem[33]), 32'hCD);
    bad = 0;
    for (int i = 0; i < M; i++) if (mem[i] !== gmem[i]) bad++;
    chk("mem_image", 32'(bad), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
